// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM states and
// stream protocol field widths.
package loader_pkg;

  localparam int LEN_W  = 16;
  localparam int CSUM_W = 8;

  typedef enum logic [2:0] {
    LEN_HI  = 3'd0,
    LEN_LO  = 3'd1,
    DATA_HI = 3'd2,
    DATA_LO = 3'd3,
    CHECK   = 3'd4,
    DONE    = 3'd5,
    ERROR   = 3'd6
  } loader_state_e;

endpackage

// File: rtl/byte_pair_assembler.sv
// Pairs incoming data bytes (high first) into 16-bit words and keeps the
// running XOR of every data byte seen since the last clear.
module byte_pair_assembler
  import loader_pkg::*;
(
  input  logic              clock,
  input  logic              clear,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              byte_is_lo,
  output logic [15:0]       word,
  output logic              word_valid,
  output logic [CSUM_W-1:0] xor_acc
);

  logic [7:0]        hi_q, hi_d;
  logic [15:0]       word_q, word_d;
  logic              word_valid_q, word_valid_d;
  logic [CSUM_W-1:0] xor_q, xor_d;

  always_comb begin
    hi_d         = hi_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    xor_d        = xor_q;
    if (byte_valid) begin
      xor_d = xor_q ^ byte_in;
      if (byte_is_lo) begin
        word_d       = {hi_q, byte_in};
        word_valid_d = 1'b1;
      end else begin
        hi_d = byte_in;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      hi_q         <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      xor_q        <= '0;
    end else begin
      hi_q         <= hi_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      xor_q        <= xor_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign xor_acc    = xor_q;

endmodule

// File: rtl/program_loader.sv
// Boot loader: parses a length-prefixed, XOR-checksummed byte stream and
// writes it into instruction memory from address 0, holding the CPU in clear.
module program_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              clear,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] im_w_addr,
  output logic [15:0]       im_w_data,
  output logic              im_w_wr,
  output logic              cpu_clear,
  output logic              done,
  output logic              error
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  loader_state_e     state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              cpu_clear_q, cpu_clear_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              data_byte;
  logic              data_is_lo;
  logic [LEN_W-1:0]  n_full;
  logic [CSUM_W-1:0] csum;

  byte_pair_assembler u_asm (
    .clock      (clock),
    .clear      (clear),
    .byte_in    (rx_data),
    .byte_valid (data_byte),
    .byte_is_lo (data_is_lo),
    .word       (im_w_data),
    .word_valid (im_w_wr),
    .xor_acc    (csum)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    addr_d     = addr_q;
    data_byte  = 1'b0;
    data_is_lo = 1'b0;
    n_full     = {len_q[15:8], rx_data};
    if (rx_valid) begin
      case (state_q)
        LEN_HI: begin
          len_d   = {rx_data, 8'h00};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = n_full;
          if (n_full > MAX_LEN)  state_d = ERROR;
          else if (n_full == '0) state_d = CHECK;
          else                   state_d = DATA_HI;
        end
        DATA_HI: begin
          data_byte = 1'b1;
          state_d   = DATA_LO;
        end
        DATA_LO: begin
          data_byte  = 1'b1;
          data_is_lo = 1'b1;
          addr_d     = count_q[ADDR_W-1:0];
          count_d    = count_q + 1'b1;
          // Counter is one bit wider than the address so N = depth terminates cleanly.
          state_d    = (LEN_W'(count_d) == len_q) ? CHECK : DATA_HI;
        end
        CHECK: begin
          state_d = (rx_data == csum) ? DONE : ERROR;
        end
        default: ;
      endcase
    end
    cpu_clear_d = (state_d != DONE);
    done_d      = (state_d == DONE);
    error_d     = (state_d == ERROR);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q     <= LEN_HI;
      len_q       <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      cpu_clear_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      addr_q      <= addr_d;
      cpu_clear_q <= cpu_clear_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign im_w_addr = addr_q;
  assign cpu_clear = cpu_clear_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected writes are queued as bytes
// are driven and matched against the write port as pulses appear.
module tb_program_loader;

  localparam int ADDR_W = 7;

  logic              clock = 1'b0;
  logic              clear;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic [ADDR_W-1:0] im_w_addr;
  logic [15:0]       im_w_data;
  logic              im_w_wr;
  logic              cpu_clear;
  logic              done;
  logic              error;

  int n_checks = 0;
  int n_errors = 0;
  int writes_seen = 0;
  bit wr_prev = 1'b0;

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [15:0]       exp_data_q[$];
  logic [15:0]       prog[$];

  program_loader #(.ADDR_W(ADDR_W)) dut (
    .clock     (clock),
    .clear     (clear),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .im_w_addr (im_w_addr),
    .im_w_data (im_w_data),
    .im_w_wr   (im_w_wr),
    .cpu_clear (cpu_clear),
    .done      (done),
    .error     (error)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (im_w_wr) begin
      writes_seen++;
      check_eq("wr_pulse_single", 32'(wr_prev), 32'd0);
      check_eq("wr_expected", 32'(exp_addr_q.size() != 0), 32'd1);
      if (exp_addr_q.size() != 0) begin
        check_eq("wr_addr", 32'(im_w_addr), 32'(exp_addr_q.pop_front()));
        check_eq("wr_data", 32'(im_w_data), 32'(exp_data_q.pop_front()));
      end
    end
    wr_prev = im_w_wr;
  end

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int idle;
    idle = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
    rx_valid = 1'b0;
    repeat (idle) @(negedge clock);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  // Sends every word in prog with expectations queued; returns the XOR of all data bytes.
  task automatic send_words(input int first, input int count, input int max_gap,
                            output logic [7:0] csum);
    csum = 8'h00;
    for (int i = first; i < first + count; i++) begin
      csum = csum ^ prog[i][15:8] ^ prog[i][7:0];
      send_byte(prog[i][15:8], max_gap);
      exp_addr_q.push_back(ADDR_W'(i));
      exp_data_q.push_back(prog[i]);
      send_byte(prog[i][7:0], max_gap);
    end
  endtask

  task automatic send_len(input logic [15:0] n, input int max_gap);
    send_byte(n[15:8], max_gap);
    send_byte(n[7:0], max_gap);
  endtask

  task automatic pulse_clear();
    clear    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    clear = 1'b0;
    writes_seen = 0;
  endtask

  task automatic check_status(input string tag, input bit exp_done, input bit exp_err);
    check_eq({tag, "_done"}, 32'(done), 32'(exp_done));
    check_eq({tag, "_error"}, 32'(error), 32'(exp_err));
    check_eq({tag, "_cpu_clear"}, 32'(cpu_clear), 32'(!exp_done));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_wr"}, 32'(im_w_wr), 32'd0);
    check_eq({tag, "_addr"}, 32'(im_w_addr), 32'd0);
    check_eq({tag, "_data"}, 32'(im_w_data), 32'd0);
    check_status(tag, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] csum;
    logic [7:0] part;
    clear    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(negedge clock);
    clear = 1'b0;
    check_reset_outputs("reset");

    // Nominal load, back-to-back bytes
    prog = '{16'h1234, 16'hABCD, 16'h0F0F};
    send_len(16'd3, 0);
    send_words(0, 3, 0, csum);
    check_eq("nominal_csum_model", 32'(csum), 32'h40);
    send_byte(csum, 0);
    check_status("nominal", 1'b1, 1'b0);
    check_eq("nominal_writes", writes_seen, 3);
    check_eq("nominal_pending", exp_addr_q.size(), 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 0);
    check_status("nominal_after_extra", 1'b1, 1'b0);
    check_eq("nominal_extra_writes", writes_seen, 3);

    // Bad checksum: writes still happen, then error is sticky
    pulse_clear();
    send_len(16'd3, 0);
    send_words(0, 3, 0, csum);
    send_byte(8'h00, 0);
    check_status("badcsum", 1'b0, 1'b1);
    check_eq("badcsum_writes", writes_seen, 3);
    for (int i = 0; i < 4; i++) send_byte(8'(i), 0);
    check_status("badcsum_after_extra", 1'b0, 1'b1);
    check_eq("badcsum_extra_writes", writes_seen, 3);

    // Oversize length
    pulse_clear();
    send_len(16'd129, 0);
    check_status("oversize", 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_byte(8'h40, 0);
    check_eq("oversize_writes", writes_seen, 0);
    check_status("oversize_hold", 1'b0, 1'b1);

    // Empty program
    pulse_clear();
    send_len(16'd0, 0);
    check_status("empty_pending", 1'b0, 1'b0);
    send_byte(8'h00, 0);
    check_status("empty", 1'b1, 1'b0);
    check_eq("empty_writes", writes_seen, 0);

    // Full-depth load with random idle gaps
    pulse_clear();
    prog = {};
    for (int i = 0; i < 128; i++) prog.push_back(16'($urandom));
    send_len(16'd128, 3);
    send_words(0, 128, 3, csum);
    check_status("full_before_csum", 1'b0, 1'b0);
    check_eq("full_last_addr", 32'(im_w_addr), 32'd127);
    send_byte(csum, 3);
    check_status("full", 1'b1, 1'b0);
    check_eq("full_writes", writes_seen, 128);
    check_eq("full_pending", exp_addr_q.size(), 0);

    // Clear mid-load after two of four words
    pulse_clear();
    prog = '{16'hDEAD, 16'hBEEF, 16'h5555, 16'hAAAA};
    send_len(16'd4, 0);
    send_words(0, 2, 0, part);
    pulse_clear();
    check_reset_outputs("midclear");
    check_eq("midclear_pending", exp_addr_q.size(), 0);

    prog = '{16'h00FF};
    send_len(16'd1, 0);
    send_words(0, 1, 0, csum);
    check_eq("reload_csum_model", 32'(csum), 32'hFF);
    send_byte(csum, 0);
    check_status("reload", 1'b1, 1'b0);
    check_eq("reload_writes", writes_seen, 1);

    // clear on the same edge as a valid byte: that byte must be dropped
    clear    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    @(negedge clock);
    clear    = 1'b0;
    rx_valid = 1'b0;
    writes_seen = 0;
    check_reset_outputs("clear_vs_valid");
    prog = '{16'h1234};
    send_len(16'd1, 0);
    send_words(0, 1, 0, csum);
    send_byte(csum, 0);
    check_status("clear_vs_valid_load", 1'b1, 1'b0);
    check_eq("clear_vs_valid_writes", writes_seen, 1);

    repeat (2) @(negedge clock);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
